calc_key_conditioner: RTL

- Front-end stage feeding the calculator core.
- Takes the raw active-low operation buttons (plus, minus, equal) and the 8-bit operand switches.
- Synchronises and debounces each button, then emits single-cycle press pulses.
- Captures the operand on each accepted press, so the core sees clean, one-cycle events with a stable operand.

---
 rtl/calc_key_conditioner.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/calc_key_conditioner.sv
// Button front-end for the calculator core: synchronise, debounce and arbitrate three
// active-low buttons into one-cycle press pulses with a captured operand. Auto-repeat on
// plus/minus is compiled in when CALC_KEY_AUTO_REPEAT_EN is defined.
module calc_key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned REPEAT_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       plus_n,
    input  logic       minus_n,
    input  logic       equal_n,
    input  logic [7:0] data_in,
    output logic       plus_p,
    output logic       minus_p,
    output logic       equal_p,
    output logic [7:0] data_q,
    output logic [1:0] last_op
);

    localparam int unsigned NCH      = 3;
    localparam int unsigned CH_PLUS  = 0;
    localparam int unsigned CH_MINUS = 1;
    localparam int unsigned CH_EQUAL = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_PLUS  = 2'b01,
        OP_MINUS = 2'b10
    } op_e;

    if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must lie in 1..255");
    end
    if (((64'(DEBOUNCE_CYCLES) - 64'd1) >> CNT_W) != 64'd0) begin : g_bad_cnt_w
        $error("CNT_W too narrow to hold DEBOUNCE_CYCLES-1");
    end
    if (REPEAT_CYCLES == 0) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be at least 1");
    end

    logic             btn_n    [NCH];
    logic             s1_q     [NCH];
    logic             s2_q     [NCH];
    logic             db_q     [NCH];
    logic             db_d     [NCH];
    logic [CNT_W-1:0] cnt_q    [NCH];
    logic [CNT_W-1:0] cnt_d    [NCH];
    logic             press_ev [NCH];
    logic             raw_ev   [NCH];

    logic [NCH-1:0] pulse_q, pulse_d;
    logic [7:0]     data_reg_q, data_d;
    op_e            op_q, op_d;

    assign btn_n[CH_PLUS]  = plus_n;
    assign btn_n[CH_MINUS] = minus_n;
    assign btn_n[CH_EQUAL] = equal_n;

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        always_comb begin
            db_d[ch]     = db_q[ch];
            cnt_d[ch]    = '0;
            press_ev[ch] = 1'b0;
            if (s2_q[ch] != db_q[ch]) begin
                if (cnt_q[ch] == CNT_LAST) begin
                    db_d[ch]     = s2_q[ch];
                    press_ev[ch] = ~s2_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q[ch]  <= 1'b1;
                s2_q[ch]  <= 1'b1;
                db_q[ch]  <= 1'b1;
                cnt_q[ch] <= '0;
            end else begin
                s1_q[ch]  <= btn_n[ch];
                s2_q[ch]  <= s1_q[ch];
                db_q[ch]  <= db_d[ch];
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

`ifdef CALC_KEY_AUTO_REPEAT_EN
    localparam int unsigned RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q  [2];
    logic [RPT_W-1:0] rpt_d  [2];
    logic             rpt_ev [2];

    // db_q is still released on the press edge, so the count starts from 0 right after it
    for (genvar ch = 0; ch < 2; ch++) begin : g_rpt
        always_comb begin
            rpt_d[ch]  = '0;
            rpt_ev[ch] = 1'b0;
            if (!db_q[ch]) begin
                if (rpt_q[ch] == RPT_LAST) begin
                    rpt_ev[ch] = 1'b1;
                end else begin
                    rpt_d[ch] = rpt_q[ch] + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rpt_q[ch] <= '0;
            end else begin
                rpt_q[ch] <= rpt_d[ch];
            end
        end
    end

    assign raw_ev[CH_PLUS]  = press_ev[CH_PLUS] | rpt_ev[CH_PLUS];
    assign raw_ev[CH_MINUS] = press_ev[CH_MINUS] | rpt_ev[CH_MINUS];
    assign raw_ev[CH_EQUAL] = press_ev[CH_EQUAL];
`else
    assign raw_ev[CH_PLUS]  = press_ev[CH_PLUS];
    assign raw_ev[CH_MINUS] = press_ev[CH_MINUS];
    assign raw_ev[CH_EQUAL] = press_ev[CH_EQUAL];
`endif

    // Fixed priority equal > minus > plus; losing events are dropped
    always_comb begin
        pulse_d = '0;
        data_d  = data_reg_q;
        op_d    = op_q;
        if (raw_ev[CH_EQUAL]) begin
            pulse_d[CH_EQUAL] = 1'b1;
            data_d            = data_in;
        end else if (raw_ev[CH_MINUS]) begin
            pulse_d[CH_MINUS] = 1'b1;
            data_d            = data_in;
            op_d              = OP_MINUS;
        end else if (raw_ev[CH_PLUS]) begin
            pulse_d[CH_PLUS] = 1'b1;
            data_d           = data_in;
            op_d             = OP_PLUS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q    <= '0;
            data_reg_q <= '0;
            op_q       <= OP_NONE;
        end else begin
            pulse_q    <= pulse_d;
            data_reg_q <= data_d;
            op_q       <= op_d;
        end
    end

    assign plus_p  = pulse_q[CH_PLUS];
    assign minus_p = pulse_q[CH_MINUS];
    assign equal_p = pulse_q[CH_EQUAL];
    assign data_q  = data_reg_q;
    assign last_op = op_q;

endmodule
